// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, start, 8 data bits LSB first, odd parity, stop, ack.
// Define PS2_HOST_TX_ACK_CHECK_EN to turn a missing device ack into an error pulse instead of done.
module ps2_host_tx #(
    parameter int C_CLK_HZ     = 40000000,
    parameter int C_INHIBIT_US = 100,
    parameter int C_TIMEOUT_MS = 15
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);
    localparam int INHIBIT_CYC = C_CLK_HZ / 1000000 * C_INHIBIT_US;
    localparam int TIMEOUT_CYC = C_CLK_HZ / 1000 * C_TIMEOUT_MS;
    localparam int CW          = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RELEASE, S_SEND, S_ACK, S_WAITIDLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    idx, idx_n;
    logic [9:0]    frame, frame_n;
    logic          clk_oe_n, data_oe_n, ready_n, done_n, error_n;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev, fall, timed;

    // Pad synchronizers; the extra clock flop turns a high-to-low transition into a one-cycle strobe.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2clk_i};
            data_sync <= {data_sync[0], ps2data_i};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            frame      <= '0;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            frame      <= frame_n;
            ps2clk_oe  <= clk_oe_n;
            ps2data_oe <= data_oe_n;
            tx_ready   <= ready_n;
            busy       <= ~ready_n;
            done       <= done_n;
            error      <= error_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        frame_n   = frame;
        clk_oe_n  = ps2clk_oe;
        data_oe_n = ps2data_oe;
        ready_n   = tx_ready;
        done_n    = 1'b0;
        error_n   = 1'b0;
        // Once the clock is handed to the device, every cycle counts toward the frame timeout.
        timed     = (state == S_RELEASE) || (state == S_SEND) ||
                    (state == S_ACK) || (state == S_WAITIDLE);
        if (timed)
            cnt_n = cnt + 1'b1;

        if (timed && cnt == CW'(TIMEOUT_CYC)) begin
            state_n   = S_IDLE;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            ready_n   = 1'b1;
            error_n   = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        frame_n  = {1'b1, ~^tx_data, tx_data};
                        cnt_n    = '0;
                        clk_oe_n = 1'b1;
                        ready_n  = 1'b0;
                        state_n  = S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(INHIBIT_CYC - 1)) begin
                        data_oe_n = 1'b1;
                        cnt_n     = '0;
                        state_n   = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    clk_oe_n = 1'b0;
                    idx_n    = '0;
                    state_n  = S_SEND;
                end
                S_SEND: begin
                    if (fall) begin
                        data_oe_n = ~frame[idx];
                        idx_n     = idx + 1'b1;
                        if (idx == 4'd9)
                            state_n = S_ACK;
                    end
                end
                S_ACK: begin
                    if (fall) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
                        if (data_sync[1]) begin
                            clk_oe_n  = 1'b0;
                            data_oe_n = 1'b0;
                            ready_n   = 1'b1;
                            error_n   = 1'b1;
                            state_n   = S_IDLE;
                        end else begin
                            state_n = S_WAITIDLE;
                        end
`else
                        state_n = S_WAITIDLE;
`endif
                    end
                end
                S_WAITIDLE: begin
                    if (clk_sync[1] && data_sync[1]) begin
                        ready_n = 1'b1;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the DUT and
// captures the bits; a monitor checks each done/error pulse against the queued expectation.
module tb_ps2_host_tx;
    localparam int INHIBIT_CYC = 100;   // 1 MHz clock, 100 us inhibit
    localparam int TIMEOUT_CYC = 2000;  // 1 MHz clock, 2 ms timeout
    localparam int DEV_ACK = 0, DEV_NOACK = 1, DEV_NOCLK = 2;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error, ps2clk_oe, ps2data_oe;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       ps2clk_i, ps2data_i;

    // Open-collector bus: either side pulling low wins.
    assign ps2clk_i  = ~(ps2clk_oe | dev_clk_low);
    assign ps2data_i = ~(ps2data_oe | dev_data_low);

    ps2_host_tx #(.C_CLK_HZ(1000000), .C_INHIBIT_US(100), .C_TIMEOUT_MS(2)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
        .ps2clk_i(ps2clk_i), .ps2data_i(ps2data_i),
        .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        bit         exp_err;
        bit         chk_bits;
        bit         chk_to;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] cap_q[$];
    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    int dev_mode = DEV_ACK;
    bit dev_abort = 0, dev_active = 0;
    int dev_falls = 0;
    int inhib_len = 0, inhib_run = 0, release_cyc = 0;
    int n_done = 0, n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Frame as the device should see it on the wire: data LSB first, odd parity, stop = 1.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    // Device model: answers a host request (clock released, data low) with 11 clock pulses.
    task automatic run_device();
        int h = int'($urandom_range(8, 20));
        logic [9:0] bits = '0;
        dev_active = 1;
        dev_falls  = 0;
        repeat (h) @(negedge clk_i);
        for (int i = 0; i < 11 && !dev_abort; i++) begin
            dev_clk_low = 1'b1;
            dev_falls++;
            repeat (h) @(negedge clk_i);
            dev_clk_low = 1'b0;
            if (i < 10) bits[i] = ps2data_i;
            if (i == 9) begin
                cap_q.push_back(bits);
                dev_data_low = (dev_mode == DEV_ACK);
            end
            repeat (h) @(negedge clk_i);
        end
        dev_data_low = 1'b0;
        dev_clk_low  = 1'b0;
        dev_active   = 0;
    endtask

    initial forever begin
        @(negedge clk_i);
        if (rstn_i && !ps2clk_oe && ps2data_oe && dev_mode != DEV_NOCLK) run_device();
    end

    // Monitor: tracks inhibit length and clock release, scores every done/error pulse.
    initial begin
        exp_t e;
        logic [9:0] c;
        bit prev_clk_oe = 0, pulse_prev = 0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                inhib_run  = 0;
                pulse_prev = 0;
            end else begin
                if (ps2clk_oe && !ps2data_oe) inhib_run++;
                else if (ps2clk_oe && ps2data_oe && inhib_run != 0) begin
                    inhib_len = inhib_run;
                    inhib_run = 0;
                end else inhib_run = 0;
                if (prev_clk_oe && !ps2clk_oe && ps2data_oe) release_cyc = cyc;
                if (pulse_prev) chk("pulse_width", int'({done, error}), 0);
                pulse_prev = done | error;
                if (done || error) begin
                    if (done) n_done++;
                    if (error) n_err++;
                    chk("done_error_excl", int'(done & error), 0);
                    chk("ready_busy_at_pulse", int'({tx_ready, busy}), 2);
                    chk("oe_released_at_pulse", int'({ps2clk_oe, ps2data_oe}), 0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_pulse: done=%0b error=%0b with no request outstanding",
                                 done, error);
                    end else begin
                        e = exp_q.pop_front();
                        chk("outcome_error", int'(error), int'(e.exp_err));
                        chk("inhibit_cycles", inhib_len, INHIBIT_CYC);
                        if (e.chk_to) chk("timeout_cycles", cyc - release_cyc, TIMEOUT_CYC);
                        if (e.chk_bits) begin
                            if (cap_q.size() == 0) begin
                                n_checks++;
                                $display("FAIL frame_captured: no bits seen by device for 0x%0h", e.data);
                            end else begin
                                c = cap_q.pop_front();
                                chk("frame_bits", int'(c), int'(ref_frame(e.data)));
                            end
                        end
                    end
                end
            end
            prev_clk_oe = ps2clk_oe;
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!tx_ready && n < 5000) begin @(negedge clk_i); n++; end
        if (n >= 5000) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic push_exp(input logic [7:0] d, input int mode);
        exp_t e;
        e.data     = d;
        e.chk_bits = (mode != DEV_NOCLK);
        e.chk_to   = (mode == DEV_NOCLK);
        e.exp_err  = (mode == DEV_NOCLK) || (mode == DEV_NOACK && ACK_CHK);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input int mode);
        dev_mode = mode;
        @(negedge clk_i);
        wait_ready("send");
        tx_valid = 1'b1;
        tx_data  = d;
        push_exp(d, mode);
        @(negedge clk_i);
        tx_valid = 1'b0;
        chk("accept_latency", int'({ps2clk_oe, tx_ready, busy}), 5);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || dev_active || !tx_ready) && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        chk({name, "_completes"}, int'(n < 20000), 1);
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        int d0, e0, n;
        logic [7:0] d;
        repeat (3) @(negedge clk_i);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_clk_oe", int'(ps2clk_oe), 0);
        chk("rst_data_oe", int'(ps2data_oe), 0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        send(8'hF4, DEV_ACK);
        wait_idle("f4");

        // Back-to-back: tx_valid held, second byte taken as soon as the first completes.
        d0 = n_done; e0 = n_err;
        dev_mode = DEV_ACK;
        wait_ready("b2b");
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        push_exp(8'hFF, DEV_ACK);
        @(negedge clk_i);
        tx_data = 8'hED;
        wait_ready("b2b2");
        chk("b2b_accept_on_done", int'(done), 1);
        push_exp(8'hED, DEV_ACK);
        @(negedge clk_i);
        tx_valid = 1'b0;
        wait_idle("b2b");
        chk("b2b_done_count", n_done - d0, 2);
        chk("b2b_error_count", n_err - e0, 0);

        send(8'($urandom), DEV_NOCLK);
        wait_idle("timeout");
        chk("timeout_after_ready", int'({tx_ready, ps2clk_oe, ps2data_oe}), 4);

        d0 = n_done; e0 = n_err;
        send(8'($urandom), DEV_NOACK);
        wait_idle("noack");
        chk("noack_error_count", n_err - e0, int'(ACK_CHK));
        chk("noack_done_count", n_done - d0, int'(!ACK_CHK));

        // Reset while the host is driving data bit 4.
        d0 = n_done; e0 = n_err;
        send(8'hF4, DEV_ACK);
        n = 0;
        while (dev_falls < 5 && n < 5000) begin @(negedge clk_i); n++; end
        chk("reset_reached_bit4", int'(n < 5000), 1);
        repeat (6) @(negedge clk_i);
        rstn_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        chk("midrst_oe", int'({ps2clk_oe, ps2data_oe}), 0);
        chk("midrst_ready", int'({tx_ready, busy}), 2);
        rstn_i = 1'b1;
        dev_abort = 1;
        wait_idle("midrst");
        dev_abort = 0;
        chk("midrst_no_pulse", (n_done - d0) + (n_err - e0), 0);
        send(8'hF4, DEV_ACK);
        wait_idle("after_rst");

        // tx_valid while busy must be dropped.
        d0 = n_done;
        send(8'hF4, DEV_ACK);
        n = 0;
        while (dev_falls < 3 && n < 5000) begin @(negedge clk_i); n++; end
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        chk("ignored_valid_not_ready", int'(tx_ready), 0);
        @(negedge clk_i);
        tx_valid = 1'b0;
        wait_idle("ignored");
        chk("ignored_one_done", n_done - d0, 1);

        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            send(d, ($urandom_range(0, 3) == 0) ? DEV_NOACK : DEV_ACK);
            wait_idle("rand");
        end

        chk("exp_queue_empty", exp_q.size(), 0);
        chk("cap_queue_empty", cap_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the sending counterpart of the PS/2 keyboard/mouse receiver. It accepts one command byte (e.g. 0xFF reset, 0xF4 enable reporting, 0xED set LEDs) per handshake and runs the full host-request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, device acknowledge. It sits in the pixel-clock domain beside the receiver and drives the shared open-collector `ps2clk`/`ps2data` pads through active-high pull-low enables. The top level ties the pads as pad = oe ? 0 : z.

## Interface
Parameters:
- `C_CLK_HZ`, 40000000: clk_i frequency in Hz.
- `C_INHIBIT_US`, 100: clock-low inhibit time in µs. INHIBIT_CYC = C_CLK_HZ/1000000*C_INHIBIT_US.
- `C_TIMEOUT_MS`, 15: frame timeout in ms. TIMEOUT_CYC = C_CLK_HZ/1000*C_TIMEOUT_MS. Counter width is $clog2(TIMEOUT_CYC+1).

Ports:
- `clk_i`  in  1  system/pixel clock.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  command byte.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  block idle; a byte is accepted when tx_valid && tx_ready.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse: frame sent and acknowledged.
- `error`  out  1  one-cycle pulse: timeout or missing ack.
- `ps2clk_i`  in  1  raw PS/2 clock pad level (asynchronous).
- `ps2data_i`  in  1  raw PS/2 data pad level (asynchronous).
- `ps2clk_oe`  out  1  1 = pull PS/2 clock low.
- `ps2data_oe`  out  1  1 = pull PS/2 data low.

## Operation
- Input conditioning:
  - `ps2clk_i` and `ps2data_i` each pass through a 2-flop synchronizer.
  - A third flop on clock gives a falling-edge strobe `fall` (prev=1, now=0).
- Frame register: 10 bits, {1'b1 stop, parity, data[7:0]}. Parity = ~^tx_data, latched at accept.
- State machine:
  - IDLE: tx_ready=1. On accept, latch frame, clear counter, go to INHIBIT.
  - INHIBIT: ps2clk_oe=1. When counter reaches INHIBIT_CYC-1, set ps2data_oe=1 (start bit) and go to RELEASE.
  - RELEASE: one cycle with both oe=1, then ps2clk_oe=0. Clear timeout counter, bit index=0, go to SEND.
  - SEND: on each `fall`, set ps2data_oe = ~frame[idx] and increment idx. After idx=9 is driven (stop, data released), go to ACK.
  - ACK: on the next `fall`, sample synchronized data; 0 = ack. Go to WAITIDLE.
  - WAITIDLE: when synchronized clock and data are both 1, pulse done and go to IDLE.
- Timeout:
  - Counts every cycle in RELEASE, SEND, ACK and WAITIDLE.
  - At TIMEOUT_CYC: both oe=0, pulse error, go to IDLE.
- Missing ack (ack bit sampled 1): see Configuration.
- tx_valid while not tx_ready is ignored and the byte is not queued.

## Timing
- Reset (rstn_i=0 at a clk_i edge) gives state IDLE with outputs:
  - tx_ready=1
  - busy=0, done=0, error=0
  - ps2clk_oe=0, ps2data_oe=0
- Reset mid-frame releases both lines on that edge; there is no done or error pulse.
- Accept to ps2clk_oe=1: 1 cycle.
- Clock low before ps2data_oe=1: INHIBIT_CYC cycles (4000 at default).
- Data low to clock release: 1 cycle.
- Pad change to `fall`: 3 cycles of latency.
- Each data update occurs at `fall`+1 cycle, well inside the device's clock-low half period (≥30 µs).
- busy = ~tx_ready. Both are registered and change on the cycle after accept, and on the cycle of the done/error pulse.
- done and error are mutually exclusive and last exactly 1 cycle. A new accept is possible the cycle after either pulse.

## Configuration
- `PS2_HOST_TX_ACK_CHECK_EN`
  - Defined: an ack bit sampled as 1 in ACK releases both lines, pulses error and returns to IDLE without waiting in WAITIDLE.
  - Undefined: the ack value is ignored and the frame always ends through WAITIDLE with done. Timeout still produces error.

## Test plan
- Send 0xF4; device model clocks at 12.5 kHz and acks. Required:
  - Clock held low for 4000 cycles.
  - Bits sampled on rising edges: 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Exactly one done pulse; tx_ready returns to 1.
- Send 0xFF and then 0xED back-to-back. Required:
  - Parity 1 for both bytes.
  - Second accept occurs the cycle after the first done.
  - Two done pulses, no error.
- Device never clocks. Required:
  - error pulses 600000 cycles after clock release.
  - Both oe=0 afterwards; tx_ready=1.
- Device gives no ack (data high at 11th falling edge). Required:
  - With the macro defined: error pulse, no done.
  - Without the macro: done pulse.
- Assert rstn_i=0 at data bit 4. Required:
  - Both oe=0 and tx_ready=1 on the next edge.
  - No done or error pulse.
  - A following 0xF4 transfer completes normally.
- Pulse tx_valid with 0x00 during SEND of 0xF4. Required:
  - Ignored; the transmitted frame remains 0xF4.
  - Only one done pulse.
